gcm_output_stage: RTL and testbench
===================================

# gcm_output_stage

Tail stage of the AES-GCM pipeline, the consumer end of the stage chain that starts at `aes_pipeline_stage1`. It accepts typed beats from the last pipeline stage: the encrypted pre-counter block E(K,J0), ciphertext blocks, and the final GHASH value S. It buffers ciphertext in a 4-deep FIFO and drives it out on a ready/valid port. After the last ciphertext block has drained, it forms tag = S ^ E(K,J0) and pulses `o_tag_ready`. In decrypt mode it also compares the tag against an expected tag.

## Interface
- FIFO_DEPTH, 4, ciphertext buffer depth; power of two, at least 2.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-high.
- i_valid  in  1  upstream beat valid.
- o_ready  out  1  beat accepted when `i_valid & o_ready`.
- i_kind  in  2  beat kind: KIND_EKJ0=0, KIND_CT=1, KIND_GHASH=2, 3 reserved.
- i_data  in  [0:127]  beat payload; bit 0 is the MSB and byte 0 is bits 0..7.
- i_ct_bytes  in  5  valid bytes in a CT beat; legal range 1..16.
- i_decrypt  in  1  mode flag, sampled with the EKJ0 beat.
- i_expected_tag  in  [0:127]  expected tag, sampled with the GHASH beat.
- o_ct_valid  out  1  ciphertext output valid.
- i_ct_ready  in  1  downstream ready.
- o_cipher_text  out  [0:127]  ciphertext block; bytes at index ≥ `o_ct_bytes` are zero.
- o_ct_bytes  out  5  valid bytes in `o_cipher_text`.
- o_tag  out  [0:127]  tag; held until the next EKJ0 beat is accepted.
- o_tag_ready  out  1  one-cycle pulse when `o_tag` is new.
- o_tag_match  out  1  qualified by `o_tag_ready`; 1 when decrypt and `o_tag == expected`; 0 in encrypt mode.
- o_busy  out  1  high when state ≠ IDLE.
- o_error  out  1  sticky protocol error; cleared only by `rst`.

## Operation
- **FSM states:** IDLE, DATA, TAG.
- **IDLE:**
  - `o_ready=1`.
  - An accepted EKJ0 beat latches `ekj0` and the decrypt flag, then goes to DATA.
  - Any other accepted kind: dropped, `o_error` set.
- **DATA:**
  - `o_ready = (fifo_count < FIFO_DEPTH)`.
  - A CT beat with 1 ≤ `i_ct_bytes` ≤ 16: bytes at index ≥ `i_ct_bytes` are masked to zero, and data plus byte count are pushed.
  - A CT beat with `i_ct_bytes` of 0 or >16: dropped, `o_error` set.
  - A GHASH beat: `tag_reg <= i_data ^ ekj0`, the expected tag is latched, then goes to TAG.
  - An EKJ0 beat or kind 3: dropped, `o_error` set.
- **TAG:**
  - `o_ready=0`.
  - When the FIFO is empty, pulse `o_tag_ready` for one cycle, drive `o_tag_match`, return to IDLE.
- Zero ciphertext blocks (EKJ0 followed directly by GHASH) is legal.
- **FIFO:**
  - Push and pop in the same cycle are allowed when not full.
  - When full, `o_ready=0` even if a pop occurs that cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - `o_ct_valid = !empty`; the head entry is held stable while `o_ct_valid & !i_ct_ready`.
- **Reset:**
  - All registers clear: state IDLE, FIFO empty, `o_tag=0`.
  - `o_ct_valid`, `o_tag_ready`, `o_tag_match`, `o_busy`, `o_error` are 0.
  - `o_ready` is forced to 0 while `rst` is high.
  - Reset mid-instance discards FIFO contents and any partial tag.

## Timing
- **CT latency:** a beat accepted at edge N into an empty FIFO is visible on `o_cipher_text` / `o_ct_valid` after edge N; one cycle of latency.
- **CT throughput:** one beat per cycle in and out.
- **Tag latency:**
  - GHASH accepted at edge N with the FIFO empty: `o_tag_ready` is high in the cycle after edge N+1.
  - Otherwise it rises in the cycle after the edge that pops the last entry.
- **Back-to-back instances:** the next EKJ0 is accepted in the first IDLE cycle, which is the cycle after the `o_tag_ready` pulse.
- **Output timing:** all outputs are registered except `o_ready` and `o_ct_valid`, which decode directly from registers.

## Structure
- **Package `aes_gcm_pkg`:**
  - `block_t` (logic [0:127]).
  - `beat_kind_e` (KIND_EKJ0/CT/GHASH).
  - `out_state_e` (IDLE/DATA/TAG).
  - Byte-mask function `ct_mask(block_t, logic[4:0])`.
- **Sub-module `gcm_ct_fifo`:** parameterised synchronous FIFO of {block_t, 5-bit count}; exposes count/full/empty and uses the same async active-high reset.

## Test plan
- **NIST TC1 (K=0, IV=0, no data):** EKJ0 58e2fccefa7e3061367f1d57a4e7455a, then GHASH 0 → tag 58e2fccefa7e3061367f1d57a4e7455a, one `o_tag_ready` pulse, no `o_ct_valid`.
- **NIST TC2:**
  - Stimulus: EKJ0 as TC1, then CT 0388dace60b6a392f328c2b971b2fe78 (16 bytes), then GHASH f38cbb1ad69223dcc3457ae5b6b0f885.
  - Response: CT out once, then tag ab6e47d42cec13bdf53a67b21257bddf.
  - Repeat in decrypt mode with expected = that tag → `o_tag_match=1`; with one bit flipped → 0.
- **Backpressure:** hold `i_ct_ready=0` and send 6 CT beats → `o_ready` drops after 4 accepted. Then release → blocks emerge in order, and the tag pulses only after the 6th pops.
- **Partial block:** CT ffff…ff with `i_ct_bytes=5` → out ffffffffff000000…00 with `o_ct_bytes=5`. `i_ct_bytes=0` → dropped and `o_error=1`.
- **Protocol errors:** CT in IDLE, and a second EKJ0 in DATA → dropped, `o_error` sticky; the current instance's tag is unaffected.
- **Reset mid-instance:** assert `rst` with 3 blocks buffered → all outputs 0 immediately; after release, TC1 completes correctly.

Source files
------------

// File: rtl/aes_gcm_pkg.sv
// Shared types for the AES-GCM output stage: block type, beat kinds, FSM states
// and the ciphertext byte-mask helper.
package aes_gcm_pkg;

  typedef logic [0:127] block_t;

  typedef enum logic [1:0] {
    KIND_EKJ0  = 2'd0,
    KIND_CT    = 2'd1,
    KIND_GHASH = 2'd2
  } beat_kind_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAG  = 2'd2
  } out_state_e;

  localparam int BLOCK_BYTES = 16;

  // Byte 0 occupies bits 0..7; bytes at index >= n are forced to zero.
  function automatic block_t ct_mask(block_t d, logic [4:0] n);
    block_t m;
    m = d;
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      if (5'(i) >= n) m[i*8 +: 8] = 8'h00;
    end
    return m;
  endfunction

endpackage

// File: rtl/gcm_ct_fifo.sv
// Synchronous FIFO of {ciphertext block, byte count}; head is read combinationally
// from storage. Push is ignored when full, pop is ignored when empty.
module gcm_ct_fifo
  import aes_gcm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [0:127]                 push_dat_i,
  input  logic [4:0]                   push_bytes_i,
  input  logic                         pop_i,
  output logic [0:127]                 head_dat_o,
  output logic [4:0]                   head_bytes_o,
  output logic [$clog2(DEPTH):0]       count_o,
  output logic                         full_o,
  output logic                         empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  block_t         mem_q   [DEPTH];
  logic [4:0]     bytes_q [DEPTH];
  logic [AW-1:0]  wr_q, rd_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           do_push, do_pop;

  assign full_o       = (cnt_q == CW'(DEPTH));
  assign empty_o      = (cnt_q == '0);
  assign count_o      = cnt_q;
  assign head_dat_o   = mem_q[rd_q];
  assign head_bytes_o = bytes_q[rd_q];
  assign do_push      = push_i && !full_o;
  assign do_pop       = pop_i && !empty_o;

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage is cleared too so nothing stale is visible on the head after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i]   <= '0;
        bytes_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q]   <= push_dat_i;
        bytes_q[wr_q] <= push_bytes_i;
        wr_q          <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gcm_output_stage.sv
// AES-GCM tail stage: buffers ciphertext, then emits tag = S ^ E(K,J0) once the
// buffer drains, with optional tag comparison in decrypt mode.
module gcm_output_stage
  import aes_gcm_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [1:0]    i_kind,
  input  logic [0:127]  i_data,
  input  logic [4:0]    i_ct_bytes,
  input  logic          i_decrypt,
  input  logic [0:127]  i_expected_tag,
  output logic          o_ct_valid,
  input  logic          i_ct_ready,
  output logic [0:127]  o_cipher_text,
  output logic [4:0]    o_ct_bytes,
  output logic [0:127]  o_tag,
  output logic          o_tag_ready,
  output logic          o_tag_match,
  output logic          o_busy,
  output logic          o_error
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  out_state_e     state_q, state_d;
  block_t         ekj0_q, ekj0_d;
  block_t         tagr_q, tagr_d;
  block_t         exp_q, exp_d;
  block_t         tag_q, tag_d;
  logic           decrypt_q, decrypt_d;
  logic           tag_rdy_q, tag_rdy_d;
  logic           match_q, match_d;
  logic           err_q, err_d;
  logic           busy_q;
  logic           accept, push, pop, ct_ok;
  logic           fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_count;
  block_t         push_dat;

  assign o_ready    = !rst && ((state_q == IDLE) || ((state_q == DATA) && !fifo_full));
  assign accept     = i_valid && o_ready;
  assign o_ct_valid = !fifo_empty;
  assign pop        = o_ct_valid && i_ct_ready;
  assign ct_ok      = (i_ct_bytes != 5'd0) && (i_ct_bytes <= 5'd16);
  assign push_dat   = ct_mask(i_data, i_ct_bytes);

  gcm_ct_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_dat_i   (push_dat),
    .push_bytes_i (i_ct_bytes),
    .pop_i        (pop),
    .head_dat_o   (o_cipher_text),
    .head_bytes_o (o_ct_bytes),
    .count_o      (fifo_count),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    ekj0_d    = ekj0_q;
    decrypt_d = decrypt_q;
    tagr_d    = tagr_q;
    exp_d     = exp_q;
    tag_d     = tag_q;
    tag_rdy_d = 1'b0;
    match_d   = 1'b0;
    err_d     = err_q;
    push      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (i_kind == KIND_EKJ0) begin
            ekj0_d    = i_data;
            decrypt_d = i_decrypt;
            state_d   = DATA;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DATA: begin
        if (accept) begin
          case (i_kind)
            KIND_CT: begin
              if (ct_ok) push  = 1'b1;
              else       err_d = 1'b1;
            end
            KIND_GHASH: begin
              tagr_d  = i_data ^ ekj0_q;
              exp_d   = i_expected_tag;
              state_d = TAG;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      TAG: begin
        // The pulse cycle stays in TAG so the first IDLE cycle follows it.
        if (tag_rdy_q) begin
          state_d = IDLE;
        end else if (fifo_empty || ((fifo_count == CW'(1)) && pop)) begin
          tag_rdy_d = 1'b1;
          tag_d     = tagr_q;
          match_d   = decrypt_q && (tagr_q == exp_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ekj0_q    <= '0;
      decrypt_q <= 1'b0;
      tagr_q    <= '0;
      exp_q     <= '0;
      tag_q     <= '0;
      tag_rdy_q <= 1'b0;
      match_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ekj0_q    <= ekj0_d;
      decrypt_q <= decrypt_d;
      tagr_q    <= tagr_d;
      exp_q     <= exp_d;
      tag_q     <= tag_d;
      tag_rdy_q <= tag_rdy_d;
      match_q   <= match_d;
      err_q     <= err_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  assign o_tag       = tag_q;
  assign o_tag_ready = tag_rdy_q;
  assign o_tag_match = match_q;
  assign o_busy      = busy_q;
  assign o_error     = err_q;

endmodule

// File: tb/tb_gcm_output_stage.sv
// Directed bench for gcm_output_stage: NIST TC1/TC2 vectors, masking table,
// backpressure, protocol errors and mid-instance reset.
module tb_gcm_output_stage;
  import aes_gcm_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [1:0]   i_kind = 2'd0;
  logic [0:127] i_data = '0;
  logic [4:0]   i_ct_bytes = 5'd0;
  logic         i_decrypt = 1'b0;
  logic [0:127] i_expected_tag = '0;
  logic         o_ct_valid;
  logic         i_ct_ready = 1'b1;
  logic [0:127] o_cipher_text;
  logic [4:0]   o_ct_bytes;
  logic [0:127] o_tag;
  logic         o_tag_ready;
  logic         o_tag_match;
  logic         o_busy;
  logic         o_error;

  gcm_output_stage dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_kind(i_kind),
    .i_data(i_data), .i_ct_bytes(i_ct_bytes), .i_decrypt(i_decrypt),
    .i_expected_tag(i_expected_tag), .o_ct_valid(o_ct_valid), .i_ct_ready(i_ct_ready),
    .o_cipher_text(o_cipher_text), .o_ct_bytes(o_ct_bytes), .o_tag(o_tag),
    .o_tag_ready(o_tag_ready), .o_tag_match(o_tag_match), .o_busy(o_busy), .o_error(o_error)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] EKJ0   = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [127:0] CT2    = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] GHASH2 = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
  localparam logic [127:0] TAG2   = 128'hab6e47d42cec13bdf53a67b21257bddf;
  localparam logic [127:0] ONES   = {128{1'b1}};

  int total = 0;
  int bad   = 0;

  logic [127:0] ctd_q[$];
  logic [4:0]   ctb_q[$];
  int           tag_cnt = 0;
  logic [127:0] last_tag;
  logic         last_match;
  int           ct_at_tag;

  always @(negedge clk) begin
    if (o_ct_valid && i_ct_ready) begin
      ctd_q.push_back(o_cipher_text);
      ctb_q.push_back(o_ct_bytes);
    end
    if (o_tag_ready) begin
      tag_cnt++;
      last_tag   = o_tag;
      last_match = o_tag_match;
      ct_at_tag  = ctd_q.size();
    end
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic send(input logic [1:0] k, input logic [127:0] d, input logic [4:0] b,
                      input logic dec, input logic [127:0] e);
    int n;
    @(negedge clk);
    i_kind = k; i_data = d; i_ct_bytes = b; i_decrypt = dec; i_expected_tag = e;
    i_valid = 1'b1;
    n = 0;
    while (!o_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept", 128'(o_ready), 128'd1);
    @(posedge clk);
    #1 i_valid = 1'b0;
  endtask

  task automatic wait_tag(input int start);
    int n;
    n = 0;
    while (tag_cnt == start && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("tag_pulse_seen", 128'(tag_cnt - start), 128'd1);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    i_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    ctd_q.delete();
    ctb_q.delete();
  endtask

  task automatic run_tc2(input logic dec, input logic [127:0] exp_tag, input logic want_match,
                         input string name);
    int start;
    ctd_q.delete();
    ctb_q.delete();
    start = tag_cnt;
    send(KIND_EKJ0, EKJ0, 5'd0, dec, '0);
    send(KIND_CT, CT2, 5'd16, 1'b0, '0);
    chk({name, "_ct_valid_lat1"}, 128'(o_ct_valid), 128'd1);
    chk({name, "_ct_data_lat1"}, o_cipher_text, CT2);
    send(KIND_GHASH, GHASH2, 5'd0, 1'b0, exp_tag);
    wait_tag(start);
    chk({name, "_ct_count"}, 128'(ctd_q.size()), 128'd1);
    if (ctd_q.size() > 0) begin
      chk({name, "_ct_out"}, ctd_q[0], CT2);
      chk({name, "_ct_bytes"}, 128'(ctb_q[0]), 128'd16);
    end
    chk({name, "_tag"}, last_tag, TAG2);
    chk({name, "_match"}, 128'(last_match), 128'(want_match));
  endtask

  typedef struct {
    logic [127:0] din;
    logic [4:0]   nbytes;
    logic         drop;
    logic [127:0] dout;
    logic         err_after;
  } mask_vec_t;

  initial begin
    mask_vec_t tv[6];
    int start;
    int exp_n;

    tv[0] = '{ONES, 5'd5, 1'b0, 128'hffffffffff0000000000000000000000, 1'b0};
    tv[1] = '{ONES, 5'd16, 1'b0, ONES, 1'b0};
    tv[2] = '{ONES, 5'd1, 1'b0, 128'hff000000000000000000000000000000, 1'b0};
    tv[3] = '{128'h0123456789abcdeffedcba9876543210, 5'd8, 1'b0,
              128'h0123456789abcdef0000000000000000, 1'b0};
    tv[4] = '{ONES, 5'd0, 1'b1, '0, 1'b1};
    tv[5] = '{ONES, 5'd17, 1'b1, '0, 1'b1};

    // Reset state
    #1;
    chk("rst_o_ready", 128'(o_ready), 128'd0);
    chk("rst_ct_valid", 128'(o_ct_valid), 128'd0);
    chk("rst_tag", o_tag, 128'd0);
    chk("rst_tag_ready", 128'(o_tag_ready), 128'd0);
    chk("rst_busy", 128'(o_busy), 128'd0);
    chk("rst_error", 128'(o_error), 128'd0);
    do_reset();
    chk("idle_o_ready", 128'(o_ready), 128'd1);

    // TC1 with exact tag latency
    start = tag_cnt;
    send(KIND_EKJ0, EKJ0, 5'd0, 1'b0, '0);
    chk("tc1_busy", 128'(o_busy), 128'd1);
    send(KIND_GHASH, 128'd0, 5'd0, 1'b0, '0);
    @(negedge clk);
    chk("tc1_no_pulse_yet", 128'(o_tag_ready), 128'd0);
    @(negedge clk);
    chk("tc1_pulse", 128'(o_tag_ready), 128'd1);
    chk("tc1_tag", o_tag, EKJ0);
    chk("tc1_match_enc", 128'(o_tag_match), 128'd0);
    chk("tc1_ready_in_pulse", 128'(o_ready), 128'd0);
    @(negedge clk);
    chk("tc1_pulse_once", 128'(o_tag_ready), 128'd0);
    chk("tc1_idle_ready", 128'(o_ready), 128'd1);
    chk("tc1_idle_busy", 128'(o_busy), 128'd0);
    chk("tc1_pulse_count", 128'(tag_cnt - start), 128'd1);
    chk("tc1_no_ct", 128'(ctd_q.size()), 128'd0);
    chk("tc1_tag_held", o_tag, EKJ0);

    // TC2 encrypt, decrypt match, decrypt mismatch
    run_tc2(1'b0, TAG2, 1'b0, "tc2_enc");
    run_tc2(1'b1, TAG2, 1'b1, "tc2_dec_ok");
    run_tc2(1'b1, TAG2 ^ 128'd1, 1'b0, "tc2_dec_bad");

    // Backpressure: 6 beats with downstream stalled
    ctd_q.delete();
    ctb_q.delete();
    start = tag_cnt;
    i_ct_ready = 1'b0;
    send(KIND_EKJ0, EKJ0, 5'd0, 1'b0, '0);
    for (int i = 0; i < 4; i++) send(KIND_CT, {16{8'(8'h10 + i)}}, 5'd16, 1'b0, '0);
    @(negedge clk);
    i_kind = KIND_CT; i_data = {16{8'h14}}; i_ct_bytes = 5'd16; i_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_full_not_ready", 128'(o_ready), 128'd0);
      @(negedge clk);
    end
    i_valid = 1'b0;
    i_ct_ready = 1'b1;
    for (int i = 4; i < 6; i++) send(KIND_CT, {16{8'(8'h10 + i)}}, 5'd16, 1'b0, '0);
    send(KIND_GHASH, GHASH2, 5'd0, 1'b0, '0);
    wait_tag(start);
    chk("bp_ct_count", 128'(ctd_q.size()), 128'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < ctd_q.size()) chk("bp_order", ctd_q[i], {16{8'(8'h10 + i)}});
    end
    chk("bp_tag_after_6th", 128'(ct_at_tag), 128'd6);
    chk("bp_tag", last_tag, TAG2);

    // Masking table, error-producing entries last since o_error is sticky
    ctd_q.delete();
    ctb_q.delete();
    start = tag_cnt;
    exp_n = 0;
    send(KIND_EKJ0, EKJ0, 5'd0, 1'b0, '0);
    for (int i = 0; i < 6; i++) begin
      send(KIND_CT, tv[i].din, tv[i].nbytes, 1'b0, '0);
      @(negedge clk);
      @(negedge clk);
      if (!tv[i].drop) exp_n++;
      chk("mask_count", 128'(ctd_q.size()), 128'(exp_n));
      if (!tv[i].drop && ctd_q.size() > 0) begin
        chk("mask_data", ctd_q[$], tv[i].dout);
        chk("mask_bytes", 128'(ctb_q[$]), 128'(tv[i].nbytes));
      end
      chk("mask_error", 128'(o_error), 128'(tv[i].err_after));
    end
    send(KIND_GHASH, 128'd0, 5'd0, 1'b0, '0);
    wait_tag(start);
    chk("mask_tag", last_tag, EKJ0);

    // Protocol errors
    do_reset();
    chk("perr_cleared", 128'(o_error), 128'd0);
    start = tag_cnt;
    send(KIND_CT, CT2, 5'd16, 1'b0, '0);
    @(negedge clk);
    chk("perr_ct_idle_err", 128'(o_error), 128'd1);
    chk("perr_ct_idle_busy", 128'(o_busy), 128'd0);
    send(KIND_EKJ0, EKJ0, 5'd0, 1'b0, '0);
    send(KIND_CT, CT2, 5'd16, 1'b0, '0);
    send(KIND_EKJ0, ONES, 5'd0, 1'b1, '0);
    send(KIND_GHASH, GHASH2, 5'd0, 1'b0, '0);
    wait_tag(start);
    chk("perr_tag", last_tag, TAG2);
    chk("perr_match", 128'(last_match), 128'd0);
    chk("perr_ct_count", 128'(ctd_q.size()), 128'd1);
    chk("perr_sticky", 128'(o_error), 128'd1);

    // Reset with 3 blocks buffered
    i_ct_ready = 1'b0;
    send(KIND_EKJ0, EKJ0, 5'd0, 1'b0, '0);
    for (int i = 0; i < 3; i++) send(KIND_CT, {16{8'(8'h40 + i)}}, 5'd16, 1'b0, '0);
    @(negedge clk);
    chk("mrst_pre_valid", 128'(o_ct_valid), 128'd1);
    rst = 1'b1;
    #1;
    chk("mrst_ready", 128'(o_ready), 128'd0);
    chk("mrst_ct_valid", 128'(o_ct_valid), 128'd0);
    chk("mrst_ct_data", o_cipher_text, 128'd0);
    chk("mrst_ct_bytes", 128'(o_ct_bytes), 128'd0);
    chk("mrst_tag", o_tag, 128'd0);
    chk("mrst_tag_ready", 128'(o_tag_ready), 128'd0);
    chk("mrst_match", 128'(o_tag_match), 128'd0);
    chk("mrst_busy", 128'(o_busy), 128'd0);
    chk("mrst_error", 128'(o_error), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    i_ct_ready = 1'b1;
    #1;
    ctd_q.delete();
    ctb_q.delete();
    start = tag_cnt;
    send(KIND_EKJ0, EKJ0, 5'd0, 1'b0, '0);
    send(KIND_GHASH, 128'd0, 5'd0, 1'b0, '0);
    wait_tag(start);
    chk("mrst_tc1_tag", last_tag, EKJ0);
    chk("mrst_no_stale_ct", 128'(ctd_q.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
